// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit. Borrows the shared combinational ALU for
// every add/subtract and keeps HI/LO for MULT, MULTU, DIV, DIVU.
package muldiv_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         start,
  input  logic [1:0]   op,
  input  word_t        rs_data,
  input  word_t        rt_data,
  output logic         busy,
  output logic         done,
  output word_t        hi,
  output word_t        lo,
  output aluop_t       alu_opcode,
  output word_t        alu_portA,
  output word_t        alu_portB,
  input  word_t        alu_outPort
);

  localparam int CW = $clog2(ITERS);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_NEG_A    = 4'd1;
  localparam logic [3:0] S_NEG_B    = 4'd2;
  localparam logic [3:0] S_ITER     = 4'd3;
  localparam logic [3:0] S_MFIX_LO  = 4'd4;
  localparam logic [3:0] S_MFIX_INV = 4'd5;
  localparam logic [3:0] S_MFIX_INC = 4'd6;
  localparam logic [3:0] S_DFIX_LO  = 4'd7;
  localparam logic [3:0] S_DFIX_HI  = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  word_t         a_q, a_d;
  word_t         b_q, b_d;
  word_t         acc_hi_q, acc_hi_d;
  word_t         acc_lo_q, acc_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  word_t         hi_q, lo_q;

  logic  is_div, is_sgn, neg_res, add_c, sub_bw;
  word_t div_shift, b_mag;

  assign is_div    = op_q[1];
  assign is_sgn    = op_q[0];
  assign neg_res   = sign_a_q ^ sign_b_q;
  assign div_shift = {acc_hi_q[30:0], acc_lo_q[31]};
  assign b_mag     = b_q[31] ? alu_outPort : b_q;

  // The ALU has no carry-out, so recover carry/borrow from the operand and result MSBs.
  assign add_c  = (alu_portA[31] & alu_portB[31]) |
                  ((alu_portA[31] | alu_portB[31]) & ~alu_outPort[31]);
  assign sub_bw = (~alu_portA[31] & alu_portB[31]) |
                  ((~alu_portA[31] | alu_portB[31]) & alu_outPort[31]);

  // ALU drive depends only on registered state, keeping the loop through the ALU open.
  always_comb begin
    alu_opcode = ALU_ADD;
    alu_portA  = '0;
    alu_portB  = '0;
    case (state_q)
      S_NEG_A: begin
        alu_opcode = ALU_SUB;
        alu_portB  = a_q;
      end
      S_NEG_B: begin
        alu_opcode = ALU_SUB;
        alu_portB  = b_q;
      end
      S_ITER: begin
        if (is_div) begin
          alu_opcode = ALU_SUB;
          alu_portA  = div_shift;
          alu_portB  = b_q;
        end else begin
          alu_opcode = ALU_ADD;
          alu_portA  = acc_hi_q;
          alu_portB  = a_q;
        end
      end
      S_MFIX_LO, S_DFIX_LO: begin
        alu_opcode = ALU_SUB;
        alu_portB  = acc_lo_q;
      end
      S_MFIX_INV: begin
        alu_opcode = ALU_NOR;
        alu_portA  = acc_hi_q;
        alu_portB  = acc_hi_q;
      end
      S_MFIX_INC: begin
        alu_opcode = ALU_ADD;
        alu_portA  = acc_hi_q;
        alu_portB  = 32'd1;
      end
      S_DFIX_HI: begin
        alu_opcode = ALU_SUB;
        alu_portB  = acc_hi_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          a_d      = rs_data;
          b_d      = rt_data;
          acc_hi_d = '0;
          acc_lo_d = op[1] ? rs_data : rt_data;
          cnt_d    = '0;
          sign_a_d = 1'b0;
          sign_b_d = 1'b0;
          if (op[1] && (rt_data == '0)) begin
            acc_hi_d = rs_data;
            acc_lo_d = '1;
            state_d  = S_DONE;
          end else begin
            state_d = op[0] ? S_NEG_A : S_ITER;
          end
        end
      end
      S_NEG_A: begin
        sign_a_d = a_q[31];
        if (a_q[31]) a_d = alu_outPort;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        sign_b_d = b_q[31];
        b_d      = b_mag;
        acc_hi_d = '0;
        acc_lo_d = is_div ? a_q : b_mag;
        state_d  = S_ITER;
      end
      S_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          // HI[31] set means the shifted partial remainder exceeds 32 bits, so it beats any divisor.
          if (acc_hi_q[31] | ~sub_bw) begin
            acc_hi_d = alu_outPort;
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = div_shift;
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else if (acc_lo_q[0]) begin
          {acc_hi_d, acc_lo_d} = {add_c, alu_outPort, acc_lo_q[31:1]};
        end else begin
          {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[31:1]};
        end
        if (cnt_q == CW'(ITERS - 1)) begin
          if (!is_sgn)     state_d = S_DONE;
          else if (is_div) state_d = S_DFIX_LO;
          else             state_d = S_MFIX_LO;
        end
      end
      S_MFIX_LO: begin
        if (neg_res) acc_lo_d = alu_outPort;
        state_d = S_MFIX_INV;
      end
      S_MFIX_INV: begin
        if (neg_res) acc_hi_d = alu_outPort;
        state_d = S_MFIX_INC;
      end
      S_MFIX_INC: begin
        // Two's-complement carry into HI happens only when the negated LO wrapped to zero.
        if (neg_res && (acc_lo_q == '0)) acc_hi_d = alu_outPort;
        state_d = S_DONE;
      end
      S_DFIX_LO: begin
        if (neg_res) acc_lo_d = alu_outPort;
        state_d = S_DFIX_HI;
      end
      S_DFIX_HI: begin
        if (sign_a_q) acc_hi_d = alu_outPort;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        hi_q <= acc_hi_d;
        lo_q <= acc_lo_d;
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: models the shared ALU, queues expected HI/LO and
// latency per request, and a negedge monitor scores every done pulse.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic   CLK = 1'b0;
  logic   nRST;
  logic   start;
  logic [1:0] op;
  word_t  rs, rt;
  logic   busy, done;
  word_t  hi, lo;
  aluop_t alu_opcode;
  word_t  alu_portA, alu_portB, alu_outPort;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    word_t hi;
    word_t lo;
    int    lat;
    int    scyc;
  } exp_t;
  exp_t sbq[$];

  muldiv_seq dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .start      (start),
    .op         (op),
    .rs_data    (rs),
    .rt_data    (rt),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .alu_opcode (alu_opcode),
    .alu_portA  (alu_portA),
    .alu_portB  (alu_portB),
    .alu_outPort(alu_outPort)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always_comb begin
    alu_outPort = '0;
    case (alu_opcode)
      ALU_ADD: alu_outPort = alu_portA + alu_portB;
      ALU_SUB: alu_outPort = alu_portA - alu_portB;
      ALU_AND: alu_outPort = alu_portA & alu_portB;
      ALU_OR:  alu_outPort = alu_portA | alu_portB;
      ALU_XOR: alu_outPort = alu_portA ^ alu_portB;
      ALU_NOR: alu_outPort = ~(alu_portA | alu_portB);
      default: alu_outPort = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("latency", 32'(cyc - e.scyc), 32'(e.lat));
      end
    end
  end

  // Issues one request and follows it to completion; with pulses set it also fires
  // ignored starts at cycles 5 and 20 and checks the multiply ALU traffic each ITER cycle.
  task automatic run_op(input logic [1:0] o, input word_t a, input word_t b,
                        input word_t eh, input word_t el, input int lat, input bit pulses);
    int s;
    bit got, busy_ok;
    word_t mhi, mlo;
    logic [32:0] t;
    logic [64:0] w;
    @(posedge CLK); #1;
    s = cyc;
    sbq.push_back('{eh, el, lat, s});
    op = o; rs = a; rt = b; start = 1'b1;
    @(negedge CLK);
    chk("busy_before_start", {31'b0, busy}, 32'd0);
    got = 1'b0; busy_ok = 1'b1; mhi = '0; mlo = b;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(posedge CLK); #1;
      if (pulses && (k == 5 || k == 20)) begin
        start = 1'b1; op = 2'b10; rs = 32'h5; rt = 32'h0;
      end else begin
        start = 1'b0; op = o; rs = a; rt = b;
      end
      @(negedge CLK);
      if (!busy) busy_ok = 1'b0;
      if (pulses && k <= 32) begin
        chk("alu_opcode", 32'(alu_opcode), 32'(ALU_ADD));
        chk("alu_portA", alu_portA, mhi);
        chk("alu_portB", alu_portB, a);
        if (mlo[0]) begin
          t = {1'b0, mhi} + {1'b0, a};
          w = {t, mlo} >> 1;
        end else begin
          w = {1'b0, mhi, mlo} >> 1;
        end
        mhi = w[63:32];
        mlo = w[31:0];
      end
      if (done) got = 1'b1;
    end
    chk("busy_window", {31'b0, busy_ok}, 32'd1);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done expected done at cycle %0d", s + lat);
      if (sbq.size() > 0) sbq.delete(sbq.size() - 1);
    end
    @(posedge CLK); #1;
    start = 1'b0;
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    chk("done_after_done", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    nRST = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_alu_op", 32'(alu_opcode), 32'(ALU_ADD));
    chk("rst_alu_a", alu_portA, 32'd0);
    chk("rst_alu_b", alu_portB, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    run_op(2'b00, 32'd7,        32'd6,        32'd0,        32'd42,       33, 1'b0);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0);
    run_op(2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 38, 1'b0);
    run_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 37, 1'b0);
    run_op(2'b10, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1,  1'b0);
    run_op(2'b00, 32'h00010003, 32'h00020005, 32'h00000002, 32'h000B000F, 33, 1'b1);
    run_op(2'b11, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 37, 1'b0);
    run_op(2'b01, 32'd0,        32'hFFFFFFFB, 32'd0,        32'd0,        38, 1'b0);
    run_op(2'b01, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 38, 1'b0);

    // Abort a DIV in cycle 10; no result may ever appear for it.
    @(posedge CLK); #1;
    s = cyc;
    op = 2'b11; rs = 32'hFFFFFFF9; rt = 32'd2; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    chk("abort_cycle", 32'(cyc - s), 32'd10);
    nRST = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (45) @(negedge CLK);
    chk("abort_idle_busy", {31'b0, busy}, 32'd0);

    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 33, 1'b0);

    repeat (2) @(negedge CLK);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
